// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning HI/LO, with fixed-latency sequencing and a hazard stall request.
module md_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic md_start;
  logic [63:0] mul_s, mul_u, res;
  logic [31:0] abs_a, abs_b, abs_b_nz, b_nz, uq_s, ur_s, q_s, r_s, q_u, r_u;
  assign md_start = start & ~op[2];
  assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign mul_u = {32'd0, a} * {32'd0, b};
  // Signed divide via magnitudes so that 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
  assign abs_a    = a[31] ? -a : a;
  assign abs_b    = b[31] ? -b : b;
  assign abs_b_nz = (b == 32'd0) ? 32'd1 : abs_b;
  assign b_nz     = (b == 32'd0) ? 32'd1 : b;
  assign uq_s     = abs_a / abs_b_nz;
  assign ur_s     = abs_a % abs_b_nz;
  assign q_s      = (a[31] ^ b[31]) ? -uq_s : uq_s;
  assign r_s      = a[31] ? -ur_s : ur_s;
  assign q_u      = a / b_nz;
  assign r_u      = a % b_nz;
  assign res = op[1] ? (op[0] ? {r_u, q_u} : {r_s, q_s}) : (op[0] ? mul_u : mul_s);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (md_start) begin
        state_d = RUN;
        cnt_d   = op[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        pend_d  = res;
        dz_d    = op[1] & (b == 32'd0);
      end else if (start && op == 3'd4) begin
        hi_d = a;
      end else if (start && op == 3'd5) begin
        lo_d = a;
      end
    end else if (cnt_q == '0) begin
      state_d = IDLE;
      if (!dz_q) {hi_d, lo_d} = pend_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy  = (state_q == RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = d_use & (busy | md_start);
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks of md_sched latency, arithmetic, hazard stall and async reset.
module tb_md_sched;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, d_use = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic busy, stall;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;

  md_sched dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                .d_use(d_use), .busy(busy), .hi(hi), .lo(lo), .stall(stall));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 30) begin
      n++;
      step;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_lat got=%0d exp=5", n); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_res got=%h exp=fffffffffffffffa", {hi, lo}); end
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_lat got=%0d exp=5", n); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_res got=%h exp=fffffffe00000001", {hi, lo}); end
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_lat got=%0d exp=10", n); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_res got=%h exp=fffffffffffffffd", {hi, lo}); end
    issue(3'd3, 32'd7, 32'd0);
    count_busy(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divz_lat got=%0d exp=10", n); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divz_keep got=%h exp=fffffffffffffffd", {hi, lo}); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got=%h exp=0000000080000000", {hi, lo}); end
    issue(3'd3, 32'd100, 32'd7);
    count_busy(n);
    checks++; if ({hi, lo} !== 64'h0000_0002_0000_000E) begin errors++; $display("FAIL divu_res got=%h exp=000000020000000e", {hi, lo}); end
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    count_busy(n);
    checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin errors++; $display("FAIL div_negb got=%h exp=00000001fffffffd", {hi, lo}); end
  endtask

  task automatic test_mthi_mtlo;
    d_use = 1'b1; op = 3'd4; a = 32'h1234_5678; start = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got=%0b exp=0", stall); end
    step;
    checks++; if (hi !== 32'h1234_5678 || busy !== 1'b0) begin errors++; $display("FAIL mthi got hi=%h busy=%0b exp hi=12345678 busy=0", hi, busy); end
    op = 3'd5; a = 32'h9ABC_DEF0;
    step;
    start = 1'b0; d_use = 1'b0;
    checks++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0) begin errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%0b exp hi=12345678 lo=9abcdef0 busy=0", hi, lo, busy); end
    op = 3'd6; a = 32'hDEAD_BEEF; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0 || busy !== 1'b0) begin errors++; $display("FAIL reserved got=%h busy=%0b exp=123456789abcdef0 busy=0", {hi, lo}, busy); end
  endtask

  task automatic test_hazard;
    int n = 0, st = 0;
    d_use = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_issue got=%0b exp=1", stall); end
    step;
    start = 1'b0;
    while (busy && n < 30) begin
      n++;
      if (n == 2) begin op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1; end
      else if (n == 3) begin op = 3'd4; a = 32'hDEAD_BEEF; start = 1'b1; end
      else start = 1'b0;
      #1;
      if (stall) st++;
      step;
    end
    start = 1'b0;
    #1;
    checks++; if (n != 5) begin errors++; $display("FAIL hazard_lat got=%0d exp=5", n); end
    checks++; if (st != 5) begin errors++; $display("FAIL stall_busy got=%0d exp=5", st); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%0b exp=0", stall); end
    checks++; if ({hi, lo} !== 64'd15) begin errors++; $display("FAIL busy_ignore got=%h exp=000000000000000f", {hi, lo}); end
    d_use = 1'b0;
    issue(3'd1, 32'd6, 32'd7);
    n = 0;
    count_busy(n);
    checks++; if (n != 5 || {hi, lo} !== 64'd42) begin errors++; $display("FAIL back_to_back got n=%0d res=%h exp n=5 res=2a", n, {hi, lo}); end
  endtask

  task automatic test_async_reset;
    int bad = 0;
    issue(3'd3, 32'd1000, 32'd7);
    step;
    step;
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin errors++; $display("FAIL async_rst got busy=%0b res=%h exp busy=0 res=0", busy, {hi, lo}); end
    #1 rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step;
      if (busy !== 1'b0 || {hi, lo} !== 64'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL post_rst got bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mthi_mtlo;
    test_hazard;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
